// File: rtl/isa16_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : isa16_pkg                                                |
// | Description : Shared constants and types for the 16-bit ISA core and   |
// |               its instruction-memory loader.                           |
// |               INSTR_W - instruction word width                         |
// |               PC_W    - program counter / imem address width           |
// |               loader_state_t - imem_loader FSM encoding                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package isa16_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_WRITE   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } loader_state_t;

  // States in which the loader is waiting for a stream byte.
  function automatic logic is_byte_state(loader_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) ||
           (s == ST_DATA_HI) || (s == ST_DATA_LO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_timeout_ctr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : byte_timeout_ctr                                         |
// | Description : 16-bit idle counter between accepted stream bytes.       |
// |   clk_i       in   clock                                               |
// |   reset_i     in   asynchronous active-high reset                       |
// |   clr_i       in   clear (byte accepted / load started); wins over en   |
// |   en_i        in   count one idle cycle                                 |
// |   expired_o   out  counter currently equals TIMEOUT_CYCLES              |
// |   expiring_o  out  counter will equal TIMEOUT_CYCLES after this edge    |
// |   TIMEOUT_CYCLES = 0 disables both outputs.                            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module byte_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o,
  output logic expiring_o
);

  localparam logic        C_ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] C_LIMIT   = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;

  // Saturates at the limit so a stalled count never wraps back to "alive".
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && C_ENABLED && !expired_o)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired_o  = C_ENABLED && (cnt_q == C_LIMIT);
  // Lets the loader drop its registered byte_ready one cycle ahead, so no
  // byte is ever handshaken in the cycle the load is aborted.
  assign expiring_o = C_ENABLED && (cnt_d == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : imem_loader                                              |
// | Description : Byte-stream to instruction-memory writer. Stream is a    |
// |               16-bit big-endian word count N followed by N big-endian  |
// |               words written to addresses 0..N-1. Holds the CPU while   |
// |               loading and after an aborted load.                       |
// |   clk_i, reset_i          clock, async active-high reset               |
// |   start_i                 begin a load (IDLE/DONE/ERR only)            |
// |   byte_valid_i/data_i     byte source                                  |
// |   byte_ready_o            byte accepted when valid && ready            |
// |   wr_en_o/addr_o/data_o   instruction memory write port                |
// |   cpu_hold_o              OR into CPU reset                            |
// |   busy_o, done_o, error_o load status                                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module imem_loader
  import isa16_pkg::*;
#(
  parameter int unsigned ADDR_W         = PC_W,
  parameter int unsigned DEPTH          = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               byte_valid_i,
  input  logic [7:0]         byte_data_i,
  output logic               byte_ready_o,
  output logic               wr_en_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [INSTR_W-1:0] wr_data_o,
  output logic               cpu_hold_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o
);

  loader_state_t        state_q, state_d;
  logic [15:0]          len_q, len_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   data_q, data_d;
  logic                 ready_q, wr_en_q, hold_q, busy_q, done_q, error_q;

  logic                 w_accept, w_start_ok, w_len_bad, w_last_word;
  logic                 w_expired, w_expiring;
  logic [15:0]          w_len_full;

  assign w_accept    = byte_valid_i && ready_q;
  assign w_start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                   (state_q == ST_ERR));
  // Full length is judged in the LEN_LO accept cycle, before len_q holds it.
  assign w_len_full  = {len_q[15:8], byte_data_i};
  assign w_len_bad   = (w_len_full == 16'd0) || (32'(w_len_full) > DEPTH);
  assign w_last_word = (16'(addr_q) == (len_q - 16'd1));

  byte_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clr_i      (w_accept || w_start_ok),
    .en_i       (is_byte_state(state_q) && !w_accept),
    .expired_o  (w_expired),
    .expiring_o (w_expiring)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (w_start_ok) state_d = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_expired) begin
          state_d = ST_ERR;
        end else if (w_accept) begin
          len_d[15:8] = byte_data_i;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (w_expired) begin
          state_d = ST_ERR;
        end else if (w_accept) begin
          len_d[7:0] = byte_data_i;
          if (w_len_bad) begin
            state_d = ST_ERR;
          end else begin
            addr_d  = '0;
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (w_expired) begin
          state_d = ST_ERR;
        end else if (w_accept) begin
          data_d[15:8] = byte_data_i;
          state_d      = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (w_expired) begin
          state_d = ST_ERR;
        end else if (w_accept) begin
          data_d[7:0] = byte_data_i;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (w_last_word) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_DATA_HI;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      wr_en_q <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ready_q <= is_byte_state(state_d) && !w_expiring;
      wr_en_q <= (state_d == ST_WRITE);
      // ERR keeps the CPU held so a half-loaded program never runs.
      hold_q  <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      busy_q  <= is_byte_state(state_d) || (state_d == ST_WRITE);
      done_q  <= (state_d == ST_DONE);
      error_q <= (state_d == ST_ERR);
    end
  end

  assign byte_ready_o = ready_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = addr_q;
  assign wr_data_o    = data_q;
  assign cpu_hold_o   = hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_imem_loader                                           |
// | Description : Directed self-checking bench for imem_loader             |
// |               (DEPTH=1024, TIMEOUT_CYCLES=20).                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_imem_loader;

  localparam int C_ADDR_W = 10;

  logic                clk = 1'b0;
  logic                reset, start, byte_valid;
  logic [7:0]          byte_data;
  logic                byte_ready, wr_en, cpu_hold, busy, done, error;
  logic [C_ADDR_W-1:0] wr_addr;
  logic [15:0]         wr_data;

  int checks = 0;
  int errors = 0;

  logic [C_ADDR_W-1:0] wa[$];
  logic [15:0]         wd[$];

  imem_loader #(
    .ADDR_W         (C_ADDR_W),
    .DEPTH          (1024),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .cpu_hold_o   (cpu_hold),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  // Write-port monitor; wr_en is one cycle wide so one negedge sees it.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (byte_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept: byte_ready stayed 0 for byte %h, want 1", b);
    end
    @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic do_start();
    byte_valid = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if ({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h hold=%b busy=%b done=%b err=%b, want all 0",
               byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_hold, busy, byte_ready} !== 3'b000) begin
      errors++;
      $display("FAIL idle_outputs: got hold/busy/rdy=%b, want 000", {cpu_hold, busy, byte_ready});
    end
  endtask

  task automatic test_nominal();
    logic [15:0] exp_d[3];
    exp_d[0] = 16'h1234; exp_d[1] = 16'hABCD; exp_d[2] = 16'h0FF0;
    wa.delete(); wd.delete();
    do_start();
    checks++;
    if ({busy, cpu_hold, done, error} !== 4'b1100) begin
      errors++;
      $display("FAIL start_status: got busy/hold/done/err=%b, want 1100", {busy, cpu_hold, done, error});
    end
    send_word(16'h0003, 0);
    for (int k = 0; k < 3; k++) send_word(exp_d[k], 0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, cpu_hold, busy, error} !== 4'b1000) begin
      errors++;
      $display("FAIL nominal_done: got done/hold/busy/err=%b, want 1000", {done, cpu_hold, busy, error});
    end
    checks++;
    if (wa.size() != 3) begin
      errors++;
      $display("FAIL nominal_count: got %0d writes, want 3", wa.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (wa[k] !== C_ADDR_W'(k) || wd[k] !== exp_d[k]) begin
          errors++;
          $display("FAIL nominal_write%0d: got addr %h data %h, want addr %h data %h",
                   k, wa[k], wd[k], k, exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_zero_length();
    wa.delete(); wd.delete();
    do_start();
    checks++;
    if ({cpu_hold, done} !== 2'b10) begin
      errors++;
      $display("FAIL restart_from_done: got hold/done=%b, want 10", {cpu_hold, done});
    end
    send_word(16'h0000, 0);
    byte_valid = 1'b0;
    checks++;
    if ({error, cpu_hold, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL zero_len_err: got err/hold/busy/done=%b, want 1100", {error, cpu_hold, busy, done});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wa.size() != 0) begin
      errors++;
      $display("FAIL zero_len_writes: got %0d writes, want 0", wa.size());
    end
  endtask

  task automatic test_oversize();
    int bad;
    wa.delete(); wd.delete();
    do_start();
    send_word(16'h0401, 0);
    byte_valid = 1'b0;
    checks++;
    if ({error, cpu_hold, byte_ready} !== 3'b110) begin
      errors++;
      $display("FAIL oversize_err: got err/hold/rdy=%b, want 110", {error, cpu_hold, byte_ready});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wa.size() != 0) begin
      errors++;
      $display("FAIL oversize_writes: got %0d writes, want 0", wa.size());
    end
    // Maximum legal length, restarted from ERR.
    wa.delete(); wd.delete();
    do_start();
    send_word(16'h0400, 0);
    for (int k = 0; k < 1024; k++) send_word(16'((k * 37) ^ 16'hA5C3), 0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      errors++;
      $display("FAIL full_done: got done/err/hold=%b, want 100", {done, error, cpu_hold});
    end
    checks++;
    if (wa.size() != 1024) begin
      errors++;
      $display("FAIL full_count: got %0d writes, want 1024", wa.size());
    end else begin
      bad = 0;
      for (int k = 0; k < 1024; k++)
        if (wa[k] !== C_ADDR_W'(k) || wd[k] !== 16'((k * 37) ^ 16'hA5C3)) bad++;
      checks++;
      if (bad != 0 || wa[1023] !== 10'h3FF) begin
        errors++;
        $display("FAIL full_data: got %0d bad words, last addr %h, want 0 bad, last addr 3ff",
                 bad, wa[1023]);
      end
    end
  endtask

  task automatic test_gapped();
    wa.delete(); wd.delete();
    do_start();
    send_word(16'h0002, 19);
    send_word(16'hBEEF, 19);
    send_word(16'h0001, 19);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, error} !== 2'b10) begin
      errors++;
      $display("FAIL gapped_done: got done/err=%b, want 10", {done, error});
    end
    checks++;
    if (wa.size() != 2 || wa[0] !== 10'd0 || wd[0] !== 16'hBEEF ||
        wa[1] !== 10'd1 || wd[1] !== 16'h0001) begin
      errors++;
      $display("FAIL gapped_writes: got %0d writes, want (0,beef) (1,0001)", wa.size());
    end
  endtask

  task automatic test_timeout();
    wa.delete(); wd.delete();
    do_start();
    send_word(16'h0002, 0);
    send_word(16'h1111, 0);
    send_byte(8'h22, 0);
    byte_valid = 1'b0;
    repeat (19) @(negedge clk);
    checks++;
    if ({byte_ready, error} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_19: got rdy/err=%b after 19 idle cycles, want 10", {byte_ready, error});
    end
    @(negedge clk);
    checks++;
    if ({byte_ready, error} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_20: got rdy/err=%b after 20 idle cycles, want 00", {byte_ready, error});
    end
    @(negedge clk);
    checks++;
    if ({error, cpu_hold, busy, done} !== 4'b1100) begin
      errors++;
      $display("FAIL timeout_err: got err/hold/busy/done=%b, want 1100", {error, cpu_hold, busy, done});
    end
    checks++;
    if (wa.size() != 1 || wd[0] !== 16'h1111) begin
      errors++;
      $display("FAIL timeout_writes: got %0d writes, want 1 (data 1111)", wa.size());
    end
  endtask

  task automatic test_start_while_busy();
    wa.delete(); wd.delete();
    do_start();
    send_word(16'h0003, 0);
    send_word(16'h0A0A, 0);
    send_byte(8'hB0, 0);
    start = 1'b1;
    send_byte(8'h0B, 0);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_start_busy: got busy=%b, want 1", busy);
    end
    send_word(16'hC0C0, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || wa.size() != 3 ||
        wa[0] !== 10'd0 || wd[0] !== 16'h0A0A ||
        wa[1] !== 10'd1 || wd[1] !== 16'hB00B ||
        wa[2] !== 10'd2 || wd[2] !== 16'hC0C0) begin
      errors++;
      $display("FAIL busy_start_writes: got done=%b, %0d writes, want done=1 (0,0a0a)(1,b00b)(2,c0c0)",
               done, wa.size());
    end
  endtask

  task automatic test_reset_midload();
    wa.delete(); wd.delete();
    do_start();
    send_word(16'h0003, 0);
    send_word(16'h1001, 0);
    send_word(16'h2002, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b we=%b a=%h d=%h hold=%b busy=%b, want all 0",
               byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (wa.size() != 2) begin
      errors++;
      $display("FAIL midload_count: got %0d writes before reset, want 2", wa.size());
    end
    wa.delete(); wd.delete();
    do_start();
    send_word(16'h0002, 0);
    send_word(16'h7777, 0);
    send_word(16'h8888, 0);
    byte_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || wa.size() != 2 ||
        wa[0] !== 10'd0 || wd[0] !== 16'h7777 ||
        wa[1] !== 10'd1 || wd[1] !== 16'h8888) begin
      errors++;
      $display("FAIL reload_writes: got done=%b, %0d writes, want done=1 (0,7777)(1,8888)",
               done, wa.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_zero_length();
    test_oversize();
    test_gapped();
    test_timeout();
    test_start_while_busy();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a byte stream and writes 16-bit instruction words into the 10-bit-addressed instruction memory.
- Holds the CPU (datapath and PC) in reset while a load is in progress.
- Sits between a byte source (UART receiver or test host) and the write port of the instruction memory. It is the counterpart of the PC-driven read path.

Parameters:
- ADDR_W, 10, instruction memory address width; matches the 10-bit PC.
- DEPTH, 1024, maximum number of words accepted; must be <= 2**ADDR_W.
- TIMEOUT_CYCLES, 65535, idle cycles allowed between accepted bytes before the load aborts; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless the state is IDLE, DONE or ERR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  instruction memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  word address being written.
- wr_data  out  16  instruction word being written.
- cpu_hold  out  1  active-high hold; OR it into the CPU reset.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully (level).
- error  out  1  last load aborted (level).

Behaviour:
- Reset: asynchronous. State goes to IDLE. All outputs go to 0, including cpu_hold. Word counter and timeout counter clear. A reset mid-load leaves memory partially written; no rollback.
- Handshake: a byte is accepted on a cycle where byte_valid && byte_ready. byte_ready is 1 only in LEN_HI, LEN_LO, DATA_HI and DATA_LO. The source holds byte_data stable while valid and not accepted.
- Stream format: LEN (2 bytes, high byte first) = word count N. Then N words, each 2 bytes, high byte first. Word k goes to address k.
- States and transitions:
  - IDLE: waits for start. On start: go to LEN_HI, set cpu_hold=1, set busy=1, clear done and error.
  - LEN_HI: on accept, latch len[15:8]; go to LEN_LO.
  - LEN_LO: on accept, latch len[7:0] and evaluate the full length in that cycle.
    - N==0 or N>DEPTH: go to ERR.
    - Otherwise: go to DATA_HI with addr=0.
  - DATA_HI: on accept, latch wr_data[15:8]; go to DATA_LO.
  - DATA_LO: on accept, latch wr_data[7:0]; go to WRITE.
  - WRITE: one cycle.
    - wr_en=1 with wr_addr=addr and wr_data valid.
    - If addr==N-1, go to DONE; otherwise addr+1 and go to DATA_HI.
    - byte_ready=0 in this state, so each word costs at least 3 cycles.
  - DONE: done=1, busy=0, cpu_hold=0 (the CPU runs from address 0). Stays until start or reset.
  - ERR: error=1, busy=0, cpu_hold stays 1 so a half-loaded program never runs. Stays until start or reset.
- Timeout (only when TIMEOUT_CYCLES != 0):
  - A 16-bit counter clears on every accepted byte and on entry to LEN_HI.
  - It increments each cycle spent in a byte-waiting state without an accept.
  - When the counter reaches TIMEOUT_CYCLES, go to ERR on the next edge.
- Arithmetic: len is a 16-bit register. The compare against DEPTH is unsigned. addr is ADDR_W bits and never wraps, because N<=DEPTH is guaranteed.
- Simultaneous events:
  - start while busy: ignored.
  - start in DONE or ERR: restarts a load and re-asserts cpu_hold in the same edge.
  - reset: overrides everything.
- Outputs are registered; wr_en is a pure function of state==WRITE.

Decomposition:
- Shared package isa16_pkg, containing:
  - the loader state enum loader_state_t;
  - the constant INSTR_W=16;
  - the constant PC_W=10 (reused for the ADDR_W default).
- One natural sub-module: byte_timeout_ctr. It implements the timeout counter with clear and enable inputs, the TIMEOUT_CYCLES parameter and an expired output.
- The loader FSM and word assembly live in imem_loader.

Test Plan:
- Nominal 3-word load:
  - Stimulus: start, then bytes 00 03 | 12 34 | AB CD | 0F F0, byte_valid held high.
  - Response: three wr_en pulses, at (addr 0, 0x1234), (addr 1, 0xABCD), (addr 2, 0x0FF0). Then done=1 and cpu_hold=0.
- Zero length:
  - Stimulus: start, bytes 00 00.
  - Response: ERR one cycle after the second byte; error=1, cpu_hold=1, no wr_en.
- Oversize:
  - Stimulus: length 0x0401 with DEPTH=1024.
  - Response: error=1, no writes. Repeat with 0x0400 and a full stream: 1024 writes, last at addr 1023, then done=1.
- Gapped valid and timeout:
  - Stimulus: TIMEOUT_CYCLES=20; insert gaps of 19 idle cycles between bytes.
  - Response: the load completes. Then a gap of 20 cycles after a DATA_HI byte gives error=1 with no write for that word.
- Start while busy:
  - Stimulus: pulse start during DATA_LO.
  - Response: no effect; the remaining writes continue to the correct addresses.
- Reset mid-load:
  - Stimulus: assert reset after 2 of 3 words.
  - Response: all outputs 0 immediately (asynchronous). A following start with a new stream writes again from addr 0.
